// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver: FSM states,
// the divisor floor and the clamp/vote functions used by the datapath.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        WAIT_HIGH
    } state_e;

    localparam int MIN_DIV       = 8;
    localparam int MIN_DATA_BITS = 5;

    // Wide enough for any divisor width the top is likely to be built with.
    function automatic logic [63:0] clamp_div(input logic [63:0] div,
                                              input logic [63:0] min_div);
        return (div < min_div) ? min_div : div;
    endfunction

    function automatic logic [4:0] clamp_bits(input logic [4:0] bits,
                                              input logic [4:0] max_bits);
        if (bits < 5'(MIN_DATA_BITS)) return 5'(MIN_DATA_BITS);
        if (bits > max_bits)          return max_bits;
        return bits;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Serial front end: 2-flop synchroniser, bit-period counter and a 2-of-3
// vote around mid-bit, reported as a one-cycle strobe with the voted value.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CFG_W = 32
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Rx_Serial,
    input  logic             i_Start_Req,
    input  logic [CFG_W-1:0] i_Div,
    output logic             o_Rx_Sync,
    output logic             o_Bit_Strobe,
    output logic             o_Bit_Value
);

    logic             r_Sync1;
    logic             r_Sync2;
    logic [CFG_W-1:0] r_Count;
    logic             r_Samp_A;
    logic             r_Samp_B;
    logic [CFG_W-1:0] w_Half;

    assign w_Half = i_Div >> 1;

    // r_Count equals the offset into the current bit; the start request
    // marks offset 0, so the following cycle is already offset 1.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Sync1  <= 1'b1;
            r_Sync2  <= 1'b1;
            r_Count  <= '0;
            r_Samp_A <= 1'b1;
            r_Samp_B <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the two flops a real
            // shift chain; blocking ones would collapse it to a single stage.
            r_Sync1 <= i_Rx_Serial;
            r_Sync2 <= r_Sync1;
            if (i_Start_Req)
                r_Count <= CFG_W'(1);
            else if (r_Count >= i_Div - CFG_W'(1))
                r_Count <= '0;
            else
                r_Count <= r_Count + CFG_W'(1);
            if (r_Count == w_Half - CFG_W'(1)) r_Samp_A <= r_Sync2;
            if (r_Count == w_Half)             r_Samp_B <= r_Sync2;
        end
    end

    assign o_Rx_Sync    = r_Sync2;
    assign o_Bit_Strobe = (r_Count == w_Half + CFG_W'(1));
    assign o_Bit_Value  = maj3(r_Samp_A, r_Samp_B, r_Sync2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..DATA_W data bits, optional parity,
// 1/2 stop bits, break/overrun detection and a one-entry valid/ready output.
module uart_rx_cfg #(
    parameter int DATA_W  = 8,
    parameter int CFG_W   = 32,
    parameter int MIN_DIV = uart_pkg::MIN_DIV
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic [CFG_W-1:0]  i_Baud_Div,
    input  logic [4:0]        i_Data_Bits,
    input  logic              i_Parity_En,
    input  logic              i_Parity_Odd,
    input  logic              i_Stop2,
    input  logic              i_Rx_Serial,
    output logic              o_Rx_Valid,
    input  logic              i_Rx_Ready,
    output logic [DATA_W-1:0] o_Rx_Data,
    output logic              o_Parity_Err,
    output logic              o_Frame_Err,
    output logic              o_Break,
    output logic              o_Overrun
);
    import uart_pkg::*;

    localparam int IDX_W = $clog2(DATA_W + 1);

    state_e r_State, w_Next;

    logic w_Sync, w_Strobe, w_Bit, w_Start_Req;

    logic [CFG_W-1:0]  r_Div;
    logic [4:0]        r_Nbits;
    logic              r_Par_En, r_Par_Odd, r_Stop2;
    logic [IDX_W-1:0]  r_Bit_Idx;
    logic [DATA_W-1:0] r_Shift;
    logic              r_Par_Acc, r_Par_Bit, r_Stop_Idx, r_Stop1, r_Frame_Acc;

    logic              r_Valid, r_Parity_Err, r_Frame_Err, r_Break, r_Overrun;
    logic [DATA_W-1:0] r_Data;

    logic w_Last_Data, w_Done, w_Break_Cond, w_Par_Err, w_Load, w_Drop;

    uart_bit_sampler #(.CFG_W(CFG_W)) u_sampler (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Rx_Serial  (i_Rx_Serial),
        .i_Start_Req  (w_Start_Req),
        .i_Div        (r_Div),
        .o_Rx_Sync    (w_Sync),
        .o_Bit_Strobe (w_Strobe),
        .o_Bit_Value  (w_Bit)
    );

    assign w_Last_Data  = (r_Bit_Idx == IDX_W'(r_Nbits - 5'd1));
    assign w_Done       = (r_State == DONE);
    assign w_Break_Cond = (r_Shift == '0) && (!r_Par_En || !r_Par_Bit) && !r_Stop1;
    assign w_Par_Err    = r_Par_En & (r_Par_Acc ^ r_Par_Bit ^ r_Par_Odd);
    assign w_Load       = w_Done && !w_Break_Cond && (!r_Valid || i_Rx_Ready);
    assign w_Drop       = w_Done && !w_Break_Cond && r_Valid && !i_Rx_Ready;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_State <= IDLE;
        else         r_State <= w_Next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_Next      = r_State;
        w_Start_Req = 1'b0;
        unique case (r_State)
            IDLE: if (!w_Sync) begin
                w_Start_Req = 1'b1;
                w_Next      = START;
            end
            START:     if (w_Strobe) w_Next = w_Bit ? IDLE : DATA;
            DATA:      if (w_Strobe && w_Last_Data) w_Next = r_Par_En ? PARITY : STOP;
            PARITY:    if (w_Strobe) w_Next = STOP;
            STOP:      if (w_Strobe && (!r_Stop2 || r_Stop_Idx)) w_Next = DONE;
            DONE:      w_Next = w_Break_Cond ? WAIT_HIGH : IDLE;
            WAIT_HIGH: if (w_Sync) w_Next = IDLE;
            default:   w_Next = IDLE;
        endcase
    end

    // Frame assembly; configuration is frozen at the start of each frame.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Div       <= CFG_W'(MIN_DIV);
            r_Nbits     <= 5'(DATA_W);
            r_Par_En    <= 1'b0;
            r_Par_Odd   <= 1'b0;
            r_Stop2     <= 1'b0;
            r_Bit_Idx   <= '0;
            r_Shift     <= '0;
            r_Par_Acc   <= 1'b0;
            r_Par_Bit   <= 1'b0;
            r_Stop_Idx  <= 1'b0;
            r_Stop1     <= 1'b1;
            r_Frame_Acc <= 1'b0;
        end else if (w_Start_Req) begin
            r_Div       <= CFG_W'(clamp_div(64'(i_Baud_Div), 64'(MIN_DIV)));
            r_Nbits     <= clamp_bits(i_Data_Bits, 5'(DATA_W));
            r_Par_En    <= i_Parity_En;
            r_Par_Odd   <= i_Parity_Odd;
            r_Stop2     <= i_Stop2;
            r_Bit_Idx   <= '0;
            r_Shift     <= '0;
            r_Par_Acc   <= 1'b0;
            r_Par_Bit   <= 1'b0;
            r_Stop_Idx  <= 1'b0;
            r_Stop1     <= 1'b1;
            r_Frame_Acc <= 1'b0;
        end else if (w_Strobe) begin
            if (r_State == DATA) begin
                r_Shift   <= r_Shift | (DATA_W'(w_Bit) << r_Bit_Idx);
                r_Par_Acc <= r_Par_Acc ^ w_Bit;
                r_Bit_Idx <= r_Bit_Idx + IDX_W'(1);
            end
            if (r_State == PARITY) r_Par_Bit <= w_Bit;
            if (r_State == STOP) begin
                if (!w_Bit)      r_Frame_Acc <= 1'b1;
                if (!r_Stop_Idx) r_Stop1     <= w_Bit;
                r_Stop_Idx <= 1'b1;
            end
        end
    end

    // Holding register and event pulses.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Valid      <= 1'b0;
            r_Data       <= '0;
            r_Parity_Err <= 1'b0;
            r_Frame_Err  <= 1'b0;
            r_Break      <= 1'b0;
            r_Overrun    <= 1'b0;
        end else begin
            r_Break   <= w_Done && w_Break_Cond;
            r_Overrun <= w_Drop;
            if (w_Load) begin
                r_Valid      <= 1'b1;
                r_Data       <= r_Shift;
                r_Parity_Err <= w_Par_Err;
                r_Frame_Err  <= r_Frame_Acc;
            end else if (r_Valid && i_Rx_Ready) begin
                r_Valid <= 1'b0;
            end
        end
    end

    assign o_Rx_Valid   = r_Valid;
    assign o_Rx_Data    = r_Data;
    assign o_Parity_Err = r_Parity_Err;
    assign o_Frame_Err  = r_Frame_Err;
    assign o_Break      = r_Break;
    assign o_Overrun    = r_Overrun;

endmodule
